// File: rtl/hamnhan_axi_master_if.sv
// hamnhan_axi_master_if: command/response and AXI4-Lite signal bundle for hamnhan_axi_master
interface hamnhan_axi_master_if #(parameter int C_M_AXI_ADDR_WIDTH = 32);
  logic                          CMD_VALID;
  logic                          CMD_READY;
  logic                          CMD_WR;
  logic [C_M_AXI_ADDR_WIDTH-1:0] CMD_ADDR;
  logic [31:0]                   CMD_WDATA;
  logic                          RSP_VALID;
  logic                          RSP_READY;
  logic [31:0]                   RSP_RDATA;
  logic [1:0]                    RSP_RESP;
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                          M_AXI_AWVALID;
  logic                          M_AXI_AWREADY;
  logic [31:0]                   M_AXI_WDATA;
  logic [3:0]                    M_AXI_WSTRB;
  logic                          M_AXI_WVALID;
  logic                          M_AXI_WREADY;
  logic [1:0]                    M_AXI_BRESP;
  logic                          M_AXI_BVALID;
  logic                          M_AXI_BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                          M_AXI_ARVALID;
  logic                          M_AXI_ARREADY;
  logic [31:0]                   M_AXI_RDATA;
  logic [1:0]                    M_AXI_RRESP;
  logic                          M_AXI_RVALID;
  logic                          M_AXI_RREADY;
  modport master (
    input  CMD_VALID, CMD_WR, CMD_ADDR, CMD_WDATA, RSP_READY,
           M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_RESP,
           M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
  );
  modport slave (
    output CMD_VALID, CMD_WR, CMD_ADDR, CMD_WDATA, RSP_READY,
           M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_RESP,
           M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
  );
endinterface

// File: rtl/hamnhan_axi_master.sv
// hamnhan_axi_master: single-outstanding AXI4-Lite initiator driven by a command/response port.
// Defining HAMNHAN_MST_TIMEOUT_EN adds a watchdog on the B/R wait states.
module hamnhan_axi_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 16
) (
  input logic                  M_AXI_ACLK,
  input logic                  M_AXI_ARESETN,
  hamnhan_axi_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
  state_t state, state_n;
  logic accept, b_hs, r_hs, timeout;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr;
  assign cmd_addr = bus.CMD_ADDR;
  assign accept = bus.CMD_VALID && bus.CMD_READY;
  assign b_hs = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
  assign r_hs = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
  assign bus.M_AXI_WSTRB = 4'hF;
  if (C_TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("C_TIMEOUT_CYCLES must be at least 1");
  end
`ifdef HAMNHAN_MST_TIMEOUT_EN
  localparam int CW = $clog2(C_TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // restarts on every state change, so it measures time spent in the current wait state
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) cnt <= '0;
    else cnt <= (state_n != state) ? '0 : cnt + 1'b1;
  assign timeout = (state == WR_B || state == RD_R) && cnt == CW'(C_TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = bus.CMD_WR ? WR_AW_W : RD_AR;
      WR_AW_W: if ((!bus.M_AXI_AWVALID || bus.M_AXI_AWREADY) && (!bus.M_AXI_WVALID || bus.M_AXI_WREADY)) state_n = WR_B;
      WR_B:    if (b_hs || timeout) state_n = RSP;
      RD_AR:   if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) state_n = RD_R;
      RD_R:    if (r_hs || timeout) state_n = RSP;
      RSP:     if (bus.RSP_READY) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) begin
      bus.CMD_READY     <= 1'b0;
      bus.RSP_VALID     <= 1'b0;
      bus.RSP_RDATA     <= '0;
      bus.RSP_RESP      <= '0;
      bus.M_AXI_AWADDR  <= '0;
      bus.M_AXI_AWVALID <= 1'b0;
      bus.M_AXI_WDATA   <= '0;
      bus.M_AXI_WVALID  <= 1'b0;
      bus.M_AXI_BREADY  <= 1'b0;
      bus.M_AXI_ARADDR  <= '0;
      bus.M_AXI_ARVALID <= 1'b0;
      bus.M_AXI_RREADY  <= 1'b0;
    end else begin
      bus.CMD_READY     <= state_n == IDLE;
      bus.M_AXI_BREADY  <= state_n == WR_B;
      bus.M_AXI_ARVALID <= state_n == RD_AR;
      bus.M_AXI_RREADY  <= state_n == RD_R;
      bus.RSP_VALID     <= state_n == RSP;
      bus.M_AXI_AWVALID <= (accept && bus.CMD_WR) || (bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY);
      bus.M_AXI_WVALID  <= (accept && bus.CMD_WR) || (bus.M_AXI_WVALID && !bus.M_AXI_WREADY);
      if (accept && bus.CMD_WR) begin
        bus.M_AXI_AWADDR <= cmd_addr;
        bus.M_AXI_WDATA  <= bus.CMD_WDATA;
      end
      if (accept && !bus.CMD_WR) bus.M_AXI_ARADDR <= cmd_addr;
      if (b_hs || r_hs || timeout) begin
        bus.RSP_RESP  <= b_hs ? bus.M_AXI_BRESP : r_hs ? bus.M_AXI_RRESP : 2'b10;
        bus.RSP_RDATA <= r_hs ? bus.M_AXI_RDATA : '0;
      end
    end
endmodule

// File: tb/tb_hamnhan_axi_master.sv
// tb_hamnhan_axi_master: randomized transactions against a cycle-schedule and memory reference model
module tb_hamnhan_axi_master;
  localparam int AW = 32;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  always #5 clk = ~clk;
  hamnhan_axi_master_if #(.C_M_AXI_ADDR_WIDTH(AW)) bus ();
  hamnhan_axi_master #(.C_M_AXI_ADDR_WIDTH(AW), .C_TIMEOUT_CYCLES(TO)) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rst_n),
    .bus(bus.master)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus.CMD_READY), 0);
    chk({tag, "_rsp_valid"}, 64'(bus.RSP_VALID), 0);
    chk({tag, "_rsp_rdata"}, 64'(bus.RSP_RDATA), 0);
    chk({tag, "_rsp_resp"}, 64'(bus.RSP_RESP), 0);
    chk({tag, "_awvalid"}, 64'(bus.M_AXI_AWVALID), 0);
    chk({tag, "_wvalid"}, 64'(bus.M_AXI_WVALID), 0);
    chk({tag, "_bready"}, 64'(bus.M_AXI_BREADY), 0);
    chk({tag, "_arvalid"}, 64'(bus.M_AXI_ARVALID), 0);
    chk({tag, "_rready"}, 64'(bus.M_AXI_RREADY), 0);
    chk({tag, "_awaddr"}, 64'(bus.M_AXI_AWADDR), 0);
    chk({tag, "_araddr"}, 64'(bus.M_AXI_ARADDR), 0);
    chk({tag, "_wdata"}, 64'(bus.M_AXI_WDATA), 0);
    chk({tag, "_wstrb"}, 64'(bus.M_AXI_WSTRB), 64'hF);
  endtask
  task automatic clear_inputs();
    bus.CMD_VALID = 0; bus.CMD_WR = 0; bus.CMD_ADDR = 0; bus.CMD_WDATA = 0; bus.RSP_READY = 0;
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
    bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; bus.M_AXI_RDATA = 0; bus.M_AXI_RRESP = 0;
  endtask
  // One command through a reactive slave; *_dly are wait cycles before each ready/valid, 1000 = never
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input int ar_dly, input int r_dly, input int rsp_dly, input logic [1:0] resp);
    bit tmo = 0;
    int aw_end, w_end, ar_end, b_beg, b_end, r_beg, r_end, rsp_beg, rsp_end;
    int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, rsp_n = 0;
    bit aw_ok = 0, w_ok = 0, stored = 0;
    logic [31:0] aw_a = 0, w_d = 0, ar_a = 0, exp_rdata;
    logic [1:0] exp_resp;
`ifdef HAMNHAN_MST_TIMEOUT_EN
    tmo = wr ? b_dly >= TO : r_dly >= TO;
`endif
    aw_end = wr ? 1 + aw_dly : 0;
    w_end = wr ? 1 + w_dly : 0;
    ar_end = wr ? 0 : 1 + ar_dly;
    b_beg = wr ? (aw_end > w_end ? aw_end : w_end) + 1 : -1;
    b_end = !wr ? -2 : tmo ? b_beg + TO - 1 : b_beg + b_dly;
    r_beg = wr ? -1 : ar_end + 1;
    r_end = wr ? -2 : tmo ? r_beg + TO - 1 : r_beg + r_dly;
    rsp_beg = (wr ? b_end : r_end) + 1;
    rsp_end = rsp_beg + rsp_dly;
    exp_resp = tmo ? 2'b10 : resp;
    exp_rdata = (wr || tmo) ? 32'h0 : (ref_mem.exists(addr) ? ref_mem[addr] : 32'h0);
    if (wr) ref_mem[addr] = wdata;
    @(negedge clk);
    chk("cmd_ready_idle", 64'(bus.CMD_READY), 1);
    bus.CMD_VALID = 1; bus.CMD_WR = wr; bus.CMD_ADDR = addr; bus.CMD_WDATA = wdata;
    for (int cyc = 1; cyc <= rsp_end + 1; cyc++) begin
      @(negedge clk);
      chk("cmd_ready", 64'(bus.CMD_READY), 64'(cyc > rsp_end));
      chk("awvalid", 64'(bus.M_AXI_AWVALID), 64'(cyc <= aw_end));
      chk("wvalid", 64'(bus.M_AXI_WVALID), 64'(cyc <= w_end));
      chk("bready", 64'(bus.M_AXI_BREADY), 64'(cyc >= b_beg && cyc <= b_end));
      chk("arvalid", 64'(bus.M_AXI_ARVALID), 64'(cyc <= ar_end));
      chk("rready", 64'(bus.M_AXI_RREADY), 64'(cyc >= r_beg && cyc <= r_end));
      chk("rsp_valid", 64'(bus.RSP_VALID), 64'(cyc >= rsp_beg && cyc <= rsp_end));
      if (bus.M_AXI_AWVALID) chk("awaddr", 64'(bus.M_AXI_AWADDR), 64'(addr));
      if (bus.M_AXI_WVALID) chk("wdata", 64'(bus.M_AXI_WDATA), 64'(wdata));
      if (bus.M_AXI_WVALID) chk("wstrb", 64'(bus.M_AXI_WSTRB), 64'hF);
      if (bus.M_AXI_ARVALID) chk("araddr", 64'(bus.M_AXI_ARADDR), 64'(addr));
      if (bus.RSP_VALID) chk("rsp_resp", 64'(bus.RSP_RESP), 64'(exp_resp));
      if (bus.RSP_VALID) chk("rsp_rdata", 64'(bus.RSP_RDATA), 64'(exp_rdata));
      bus.CMD_VALID = !bus.CMD_READY && $urandom_range(0, 1) == 1;
      bus.CMD_WR = 1'($urandom_range(0, 1));
      bus.CMD_ADDR = $urandom;
      bus.CMD_WDATA = $urandom;
      bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && aw_n >= aw_dly;
      if (bus.M_AXI_AWVALID) aw_n++;
      if (bus.M_AXI_AWREADY) begin aw_ok = 1; aw_a = bus.M_AXI_AWADDR; end
      bus.M_AXI_WREADY = bus.M_AXI_WVALID && w_n >= w_dly;
      if (bus.M_AXI_WVALID) w_n++;
      if (bus.M_AXI_WREADY) begin w_ok = 1; w_d = bus.M_AXI_WDATA; end
      if (aw_ok && w_ok && !stored) begin slv_mem[aw_a] = w_d; stored = 1; end
      bus.M_AXI_BVALID = bus.M_AXI_BREADY && b_n >= b_dly;
      bus.M_AXI_BRESP = resp;
      if (bus.M_AXI_BREADY) b_n++;
      bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && ar_n >= ar_dly;
      if (bus.M_AXI_ARVALID) ar_n++;
      if (bus.M_AXI_ARREADY) ar_a = bus.M_AXI_ARADDR;
      bus.M_AXI_RVALID = bus.M_AXI_RREADY && r_n >= r_dly;
      bus.M_AXI_RDATA = slv_mem.exists(ar_a) ? slv_mem[ar_a] : 32'h0;
      bus.M_AXI_RRESP = resp;
      if (bus.M_AXI_RREADY) r_n++;
      bus.RSP_READY = bus.RSP_VALID && rsp_n >= rsp_dly;
      if (bus.RSP_VALID) rsp_n++;
    end
    clear_inputs();
  endtask
  initial begin
    clear_inputs();
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1;
    @(negedge clk);
    chk("cmd_ready_after_rst", 64'(bus.CMD_READY), 1);
    run_txn(1, 32'h79C0_0000, 32'h0000_0007, 0, 0, 0, 0, 0, 0, 2'b00);
    run_txn(1, 32'h79C0_0004, 32'h0000_002A, 0, 0, 0, 0, 0, 0, 2'b00);
    run_txn(0, 32'h79C0_0004, 32'h0, 0, 0, 0, 3, 0, 0, 2'b00);
    run_txn(1, 32'h79C0_0008, 32'h1234_5678, 2, 0, 1, 0, 0, 0, 2'b01);
    run_txn(1, 32'h79C0_000C, 32'hCAFE_F00D, 0, 3, 0, 0, 0, 0, 2'b11);
    run_txn(0, 32'h79C0_0000, 32'h0, 0, 0, 0, 0, 2, 5, 2'b00);
`ifdef HAMNHAN_MST_TIMEOUT_EN
    run_txn(1, 32'h79C0_0008, 32'h0BAD_0BAD, 0, 0, 1000, 0, 0, 0, 2'b00);
    run_txn(0, 32'h79C0_0008, 32'h0, 0, 0, 0, 1, 1000, 2, 2'b00);
`endif
    for (int i = 0; i < 40; i++)
      run_txn(1'($urandom_range(0, 1)), 32'h79C0_0000 + 32'(4 * $urandom_range(0, 3)), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
              $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 5),
              2'($urandom_range(0, 3)));
    @(negedge clk);
    bus.CMD_VALID = 1; bus.CMD_WR = 0; bus.CMD_ADDR = 32'h79C0_000C;
    chk("cmd_ready_pre_abort", 64'(bus.CMD_READY), 1);
    @(negedge clk);
    bus.CMD_VALID = 0;
    chk("arvalid_pre_abort", 64'(bus.M_AXI_ARVALID), 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    chk_reset_outputs("abort_hold");
    rst_n = 1;
    @(negedge clk);
    chk("cmd_ready_post_abort", 64'(bus.CMD_READY), 1);
    chk("arvalid_post_abort", 64'(bus.M_AXI_ARVALID), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rsp_valid_post_abort", 64'(bus.RSP_VALID), 0);
    end
    run_txn(0, 32'h79C0_0000, 32'h0, 1, 0, 0, 1, 1, 0, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
